// File: rtl/invaders_pkg.sv
// Shared playfield constants, bullet FSM encoding and column clamp helper
// for the invaders engine and its player-bullet generator.
package invaders_pkg;

  localparam int COLS       = 20;
  localparam int ROWS       = 16;
  localparam int PARK_Y     = 15;
  localparam int LAUNCH_ROW = 14;
  localparam int COL_W      = 5;
  localparam int ROW_W      = 4;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    READY    = 2'd1,
    FLYING   = 2'd2,
    COOLDOWN = 2'd3
  } bullet_state_t;

  // Cannon columns beyond the playfield launch from the rightmost column.
  function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W-1:0] col);
    if (col > COL_W'(COLS - 1)) return COL_W'(COLS - 1);
    return col;
  endfunction

endpackage

// File: rtl/bullet_tick_timer.sv
// Free-running movement tick: one-cycle pulse every PERIOD cycles, or every
// PERIOD/2 cycles when half is set. The period is sampled on every reload.
module bullet_tick_timer #(
  parameter int PERIOD = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic half,
  output logic tick
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] FULL_LOAD = TW'(PERIOD - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(PERIOD / 2 - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] load;

  assign load = half ? HALF_LOAD : FULL_LOAD;
  assign tick = (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (reload || tick) begin
      count_q <= load;
    end else begin
      count_q <= count_q - TW'(1);
    end
  end

endmodule

// File: rtl/bullet_engine.sv
// Player-bullet generator: one bullet in flight, stepped up one row per tick.
// Build option BULLET_AUTOFIRE_EN: a held fire button launches whenever READY.
module bullet_engine
  import invaders_pkg::*;
#(
  parameter int BULLET_PERIOD  = 1250000,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic             start,
  input  logic             fire,
  input  logic [COL_W-1:0] player_x,
  input  logic             hit,
  input  logic             level,
  output logic [COL_W-1:0] bullet_x,
  output logic [ROW_W-1:0] bullet_y,
  output logic             bullet_active,
  output logic             shot_fired,
  output bullet_state_t    state
);

  localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_TICKS - 1);

  bullet_state_t    state_q, state_d;
  logic [COL_W-1:0] x_q, x_d;
  logic [ROW_W-1:0] y_q, y_d;
  logic             act_q, act_d;
  logic             shot_q, shot_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic             sync1, sync2, trig_q;
  logic             tick, reload;

  bullet_tick_timer #(.PERIOD(BULLET_PERIOD)) u_timer (
    .clk    (clk_25MHz),
    .reset  (reset),
    .reload (reload),
    .half   (level),
    .tick   (tick)
  );

  // fire is asynchronous: two-flop synchroniser, then a registered trigger.
`ifdef BULLET_AUTOFIRE_EN
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      sync1  <= fire;
      sync2  <= sync1;
      trig_q <= sync2;
    end
  end
`else
  logic sync_prev;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      sync1     <= fire;
      sync2     <= sync1;
      sync_prev <= sync2;
      trig_q    <= sync2 & ~sync_prev;
    end
  end
`endif

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      x_q     <= '0;
      y_q     <= ROW_W'(PARK_Y);
      act_q   <= 1'b0;
      shot_q  <= 1'b0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
      shot_q  <= shot_d;
      cd_q    <= cd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    shot_d  = 1'b0;
    cd_d    = cd_q;
    reload  = 1'b0;
    unique case (state_q)
      OFF: begin
        if (start) state_d = READY;
      end
      READY: begin
        if (trig_q) begin
          state_d = FLYING;
          x_d     = clamp_col(player_x);
          y_d     = ROW_W'(LAUNCH_ROW);
          act_d   = 1'b1;
          shot_d  = 1'b1;
          reload  = 1'b1;
        end
      end
      FLYING: begin
        // A hit retires the bullet even when a step is due in the same cycle.
        if (hit || (tick && y_q == '0)) begin
          state_d = COOLDOWN;
          x_d     = '0;
          y_d     = ROW_W'(PARK_Y);
          act_d   = 1'b0;
          cd_d    = '0;
        end else if (tick) begin
          y_d = y_q - ROW_W'(1);
        end
      end
      COOLDOWN: begin
        if (tick) begin
          if (cd_q == CD_LAST) begin
            state_d = READY;
            cd_d    = '0;
          end else begin
            cd_d = cd_q + CD_W'(1);
          end
        end
      end
      default: state_d = OFF;
    endcase
  end

  assign bullet_x      = x_q;
  assign bullet_y      = y_q;
  assign bullet_active = act_q;
  assign shot_fired    = shot_q;
  assign state         = state_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine with a short bullet period and cooldown;
// expected bullet positions are queued ahead and popped one per cycle.
module tb_bullet_engine;
  import invaders_pkg::*;

  localparam int BP = 4;
  localparam int CT = 2;

  logic          clk_25MHz = 1'b0;
  logic          reset     = 1'b1;
  logic          start     = 1'b0;
  logic          fire      = 1'b0;
  logic [4:0]    player_x  = '0;
  logic          hit       = 1'b0;
  logic          level     = 1'b0;
  logic [4:0]    bullet_x;
  logic [3:0]    bullet_y;
  logic          bullet_active;
  logic          shot_fired;
  bullet_state_t state;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  bullet_engine #(.BULLET_PERIOD(BP), .COOLDOWN_TICKS(CT)) dut (
    .clk_25MHz     (clk_25MHz),
    .reset         (reset),
    .start         (start),
    .fire          (fire),
    .player_x      (player_x),
    .hit           (hit),
    .level         (level),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .shot_fired    (shot_fired),
    .state         (state)
  );

  // Clock and watchdog
  always #20 clk_25MHz = ~clk_25MHz;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_parked(input string tag);
    check(tag, {5'b0, bullet_x, bullet_y, bullet_active, shot_fired},
          {5'b0, 5'd0, 4'd15, 1'b0, 1'b0});
  endtask

  // Fire launches on the fourth edge after the press: three pre-launch cycles here.
  task automatic fire_press(input bit hold);
    fire = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (!hold) fire = 1'b0;
      check("pre_launch", {15'b0, bullet_active}, 16'd0);
    end
  endtask

  // Scoreboard
  task automatic push_exp(input logic [4:0] x, input logic [3:0] y, input logic a, input logic s);
    exp_q.push_back({x, y, a, s});
  endtask

  task automatic push_flight(input logic [4:0] x, input int y_from, input int y_to, input int per);
    for (int r = y_from; r >= y_to; r--)
      for (int k = 0; k < per; k++)
        push_exp(x, 4'(r), 1'b1, (r == y_from && k == 0));
  endtask

  task automatic check_sb(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {5'b0, bullet_x, bullet_y, bullet_active, shot_fired}, {5'b0, e});
    end
  endtask

  initial begin
    int n;
    int shots;
    int first;

    // Reset held, then fire with no start
    repeat (20) cycle();
    check_parked("reset_outputs");
    check("reset_state", 16'(state), 16'(OFF));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fire = (i % 3) != 0;
      cycle();
      push_exp(5'd0, 4'd15, 1'b0, 1'b0);
      check_sb("off_ignores_fire");
    end
    fire = 1'b0;
    repeat (4) cycle();
    check("still_off", 16'(state), 16'(OFF));

    // Arm, launch from column 7, full flight to the top row
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("armed", 16'(state), 16'(READY));
    player_x = 5'd7;
    fire_press(1'b0);
    push_flight(5'd7, 14, 0, BP);
    push_exp(5'd0, 4'd15, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      cycle();
      check_sb("flight_no_hit");
    end
    for (int i = 1; i <= 8; i++) begin
      cycle();
      check("cooldown_len", 16'(state), (i < 8) ? 16'(COOLDOWN) : 16'(READY));
    end

    // Hit coincident with a tick at row 9; fire during cooldown is dropped
    player_x = 5'd3;
    fire_press(1'b0);
    push_flight(5'd3, 14, 9, BP);
    push_exp(5'd0, 4'd15, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() > 0) begin
      cycle();
      check_sb("hit_flight");
      hit = (n == 23);
      n++;
    end
    hit = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 1) fire = 1'b1;
      if (i == 3) fire = 1'b0;
      cycle();
      push_exp(5'd0, 4'd15, 1'b0, 1'b0);
      check_sb("cooldown_fire_ignored");
    end
    check("ready_after_hit", 16'(state), 16'(READY));

    // Clamped column, fast level, async reset mid-flight at row 5
    level = 1'b1;
    player_x = 5'd25;
    fire_press(1'b0);
    push_flight(5'd19, 14, 6, BP / 2);
    push_exp(5'd19, 4'd5, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      cycle();
      check_sb("fast_clamped");
    end
    #2;
    reset = 1'b1;
    #1;
    check_parked("async_reset_park");
    check("async_reset_state", 16'(state), 16'(OFF));
    cycle();
    reset = 1'b0;
    level = 1'b0;

    // Fire held for a long window
    start = 1'b1;
    cycle();
    start = 1'b0;
    player_x = 5'd2;
    fire = 1'b1;
    shots = 0;
    first = -1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (shot_fired) begin
        shots++;
        if (first < 0) first = i;
      end
    end
    fire = 1'b0;
    check("held_first_shot", 16'(first), 16'd3);
`ifdef BULLET_AUTOFIRE_EN
    check("held_shot_count", 16'(shots), 16'd2);
`else
    check("held_shot_count", 16'(shots), 16'd1);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
